bus_region_decoder: RTL and testbench
=====================================

// Module: bus_region_decoder
// PURPOSE
// - Parametrised, registered 6809 address decoder. Next generation of the fixed SRAM/flash/UART decoder.
// - Supports N regions, each with its own base, mask, gate and wait-state count.
// - Latches the decode once per bus cycle and holds chip enables stable until the cycle ends.
// - Drives MRDY low to stretch E for slow regions.
// - Sits between the 6809 bus and the SRAM, SPI-flash and UART enables.
// PARAMETERS
// - NUM_REGIONS  4         number of decoded regions / chip enables
// - ADDR_W       16        address bus width
// - WAIT_W       3         width of each wait-state field
// - REGION_BASE  {16'hA000,16'h3000,16'h1000,16'h0000}  packed bases; region i at [i*ADDR_W +: ADDR_W]
// - REGION_MASK  {16'hFFFC,16'hF000,16'hF000,16'h0000}  packed masks; 1 = bit compared; all-zero mask = region disabled
// - REGION_WAIT  {3'd0,3'd2,3'd0,3'd0}                  packed wait states per region (i_clk cycles)
// PORTS
// - i_clk          in   1              system clock; must run >= 8x E frequency
// - i_reset        in   1              asynchronous reset, active-high
// - i_address      in   ADDR_W         6809 address bus
// - i_rw           in   1              6809 R/W (1 = read)
// - i_E            in   1              6809 E clock (asynchronous to i_clk)
// - i_Q            in   1              6809 Q clock (asynchronous to i_clk)
// - i_enable       in   1              global decode enable; sampled with the address
// - i_region_gate  in   NUM_REGIONS    per-region qualifier, e.g. FT2232 CS high; 0 blocks that region
// - o_ce           out  NUM_REGIONS    one-hot registered chip enables
// - o_hit          out  1              a region was selected this bus cycle
// - o_region_idx   out  clog2(N)       index of the selected region; 0 when !o_hit
// - o_mrdy         out  1              6809 MRDY; 0 stretches E
// - o_busy         out  1              FSM not in IDLE
// BEHAVIOUR
// - Reset (async): state=IDLE, o_ce=0, o_hit=0, o_region_idx=0, o_mrdy=1, o_busy=0, wait counter=0.
//   - Synchroniser flops for i_E and i_Q are cleared to 0.
// - i_E and i_Q each pass through a 2-flop synchroniser and a third delay flop.
//   - rise = s2 & ~s3; fall = ~s2 & s3.
// - Match for region i: ((i_address ^ BASE_i) & MASK_i) == 0 && MASK_i != 0 && i_region_gate[i] && i_enable.
//   - Overlapping matches: the lowest index wins.
// - FSM states: IDLE, WAIT, ACTIVE.
//   - IDLE, Q rise, match with WAIT_i > 0:
//     - Register o_ce[i]=1, o_hit=1, o_region_idx=i, o_mrdy=0, counter=WAIT_i; go to WAIT.
//   - IDLE, Q rise, match with WAIT_i = 0:
//     - Register o_ce[i]=1, o_hit=1, o_region_idx=i; go to ACTIVE.
//   - IDLE, Q rise, no match: o_ce=0, o_hit=0; go to ACTIVE.
//   - WAIT: counter decrements once per i_clk.
//     - On the cycle counter==1: o_mrdy returns to 1 on the next edge; go to ACTIVE.
//   - ACTIVE, E fall: o_ce=0, o_hit=0, o_region_idx=0 on the same edge; go to IDLE.
// - Latency:
//   - o_ce rises on the 3rd i_clk edge after the first edge that samples i_Q=1.
//   - o_mrdy is low for exactly WAIT_i cycles, starting on that same edge.
// - Address, i_rw, i_enable and gates are sampled only at Q rise.
//   - Later changes do not alter o_ce during the cycle.
// - Q rise while in WAIT or ACTIVE: ignored.
// - E fall while in WAIT (protocol violation):
//   - o_ce=0, o_mrdy=1; go to IDLE.
//   - Counts as a fault when DECODE_FAULT_EN is defined.
// - o_ce is never multi-hot.
// - o_mrdy is never low outside WAIT.
// CONFIGURATION
// - Macro DECODE_FAULT_EN adds ports:
//   - i_fault_clr   in   1
//   - o_fault       out  1
//   - o_fault_addr  out  ADDR_W
//   - o_fault_rw    out  1
// - Fault trigger: a Q rise with i_enable=1 and no match, or an E fall in WAIT.
//   - On trigger: o_fault=1; o_fault_addr and o_fault_rw capture the sampled bus.
//   - First fault only; later faults are ignored until i_fault_clr.
// - i_fault_clr=1 clears o_fault on the next edge. Clear and a new fault on the same edge: the new fault wins.
// - Reset value of all fault outputs is 0.
// - Macro undefined: the ports and logic are absent; unmapped cycles just produce o_hit=0.
// TESTING
// - Reset pulse mid-ACTIVE with o_ce=4'b0010 -> o_ce=0, o_mrdy=1, o_busy=0 immediately (async), before next i_clk edge.
// - Addr 16'h1234, gate=4'hF, i_enable=1, Q rise -> o_ce=4'b0010, idx=1, mrdy stays 1; E fall -> o_ce=0.
// - Addr 16'h3ABC, WAIT=2 -> o_ce=4'b0100 and o_mrdy=0 for exactly 2 i_clk cycles, then o_mrdy=1 until E fall.
// - Addr 16'h3000, i_region_gate[2]=0 -> o_ce=0, o_hit=0.
//   - With DECODE_FAULT_EN: o_fault=1, o_fault_addr=16'h3000.
// - Addr 16'hA001 then 16'hA004 in consecutive bus cycles -> first o_ce=4'b1000, second o_hit=0.
//   - Address change after Q rise does not move o_ce.
// - i_fault_clr asserted on the same edge as a new unmapped access at 16'h8000 -> o_fault stays 1, o_fault_addr=16'h8000.

Source files
------------

// File: rtl/bus_region_decoder.sv
// ---------------------------------------------------------------------------
// bus_region_decoder
//
// Registered, parametrised 6809 address decoder. It compares the bus address
// against NUM_REGIONS base/mask pairs once per bus cycle, at the synchronised
// rising edge of Q. It then holds a one-hot chip enable until E falls.
// For regions that have wait states, it pulls MRDY low to stretch E.
//
// Optional feature (macro DECODE_FAULT_EN): this build captures the first
// unmapped access, or the first E fall during a wait phase, and exposes it
// on the fault ports until it is cleared.
//
// Ports
//   i_clk          system clock; must be at least 8x the E frequency
//   i_reset        asynchronous reset, active high
//   i_address      6809 address bus
//   i_rw           6809 R/W (1 = read)
//   i_E, i_Q       6809 E and Q clocks, asynchronous to i_clk
//   i_enable       global decode enable, sampled with the address
//   i_region_gate  per-region qualifier; 0 blocks that region
//   o_ce           one-hot registered chip enables
//   o_hit          a region was selected in this bus cycle
//   o_region_idx   index of the selected region (0 when no hit)
//   o_mrdy         6809 MRDY; 0 stretches E
//   o_busy         decoder FSM is not idle
//   i_fault_clr    (DECODE_FAULT_EN) clears the captured fault
//   o_fault        (DECODE_FAULT_EN) a fault has been captured
//   o_fault_addr   (DECODE_FAULT_EN) address of the captured fault
//   o_fault_rw     (DECODE_FAULT_EN) R/W of the captured fault
// ---------------------------------------------------------------------------
module bus_region_decoder #(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 16,
    parameter int WAIT_W      = 3,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {16'hA000, 16'h3000, 16'h1000, 16'h0000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {16'hFFFC, 16'hF000, 16'hF000, 16'h0000},
    parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT = {3'd0, 3'd2, 3'd0, 3'd0},
    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [ADDR_W-1:0]      i_address,
    input  logic                   i_rw,
    input  logic                   i_E,
    input  logic                   i_Q,
    input  logic                   i_enable,
    input  logic [NUM_REGIONS-1:0] i_region_gate,
    output logic [NUM_REGIONS-1:0] o_ce,
    output logic                   o_hit,
    output logic [IDX_W-1:0]       o_region_idx,
    output logic                   o_mrdy,
    output logic                   o_busy
`ifdef DECODE_FAULT_EN
    ,
    input  logic                   i_fault_clr,
    output logic                   o_fault,
    output logic [ADDR_W-1:0]      o_fault_addr,
    output logic                   o_fault_rw
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    // -------------------------------------------------------------------
    // E / Q synchronisers: two metastability flops plus one delay flop
    // -------------------------------------------------------------------
    logic [2:0] e_sync_reg;
    logic [2:0] q_sync_reg;
    logic       e_fall;
    logic       q_rise;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            e_sync_reg <= '0;
            q_sync_reg <= '0;
        end else begin
            e_sync_reg <= {e_sync_reg[1:0], i_E};
            q_sync_reg <= {q_sync_reg[1:0], i_Q};
        end
    end

    assign q_rise = q_sync_reg[1] & ~q_sync_reg[2];
    assign e_fall = ~e_sync_reg[1] & e_sync_reg[2];

    // -------------------------------------------------------------------
    // Per-region address match
    // -------------------------------------------------------------------
    logic [NUM_REGIONS-1:0] match;
    logic [WAIT_W-1:0]      wait_val [NUM_REGIONS];

    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
        localparam logic [ADDR_W-1:0] BASE = REGION_BASE[gi*ADDR_W +: ADDR_W];
        localparam logic [ADDR_W-1:0] MASK = REGION_MASK[gi*ADDR_W +: ADDR_W];
        // An all-zero mask would match everything, so it disables the region.
        assign match[gi] = (((i_address ^ BASE) & MASK) == '0) && (MASK != '0)
                           && i_region_gate[gi] && i_enable;
        assign wait_val[gi] = REGION_WAIT[gi*WAIT_W +: WAIT_W];
    end

    // Priority encode: walking downwards lets the lowest matching index win.
    logic [NUM_REGIONS-1:0] sel_onehot;
    logic [IDX_W-1:0]       sel_idx;
    logic [WAIT_W-1:0]      sel_wait;
    logic                   any_match;

    always_comb begin
        sel_onehot = '0;
        sel_idx    = '0;
        sel_wait   = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                sel_idx       = IDX_W'(i);
                sel_wait      = wait_val[i];
            end
        end
    end

    assign any_match = |match;

    // -------------------------------------------------------------------
    // Decode FSM
    // -------------------------------------------------------------------
    state_t                 state_reg, state_next;
    logic [NUM_REGIONS-1:0] ce_reg, ce_next;
    logic                   hit_reg, hit_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic                   mrdy_reg, mrdy_next;
    logic [WAIT_W-1:0]      cnt_reg, cnt_next;

    always_comb begin
        state_next = state_reg;
        ce_next    = ce_reg;
        hit_next   = hit_reg;
        idx_next   = idx_reg;
        mrdy_next  = mrdy_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (q_rise) begin
                    if (any_match) begin
                        ce_next  = sel_onehot;
                        hit_next = 1'b1;
                        idx_next = sel_idx;
                        if (sel_wait != '0) begin
                            mrdy_next  = 1'b0;
                            cnt_next   = sel_wait;
                            state_next = WAIT;
                        end else begin
                            state_next = ACTIVE;
                        end
                    end else begin
                        // Unmapped cycle: still track it so the next Q rise
                        // is only considered after this cycle's E fall.
                        ce_next    = '0;
                        hit_next   = 1'b0;
                        idx_next   = '0;
                        state_next = ACTIVE;
                    end
                end
            end
            WAIT: begin
                if (e_fall) begin
                    // E ended while MRDY was still low: abandon the cycle.
                    ce_next    = '0;
                    hit_next   = 1'b0;
                    idx_next   = '0;
                    mrdy_next  = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - WAIT_W'(1);
                    if (cnt_reg == WAIT_W'(1)) begin
                        mrdy_next  = 1'b1;
                        state_next = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (e_fall) begin
                    ce_next    = '0;
                    hit_next   = 1'b0;
                    idx_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                ce_next    = '0;
                hit_next   = 1'b0;
                idx_next   = '0;
                mrdy_next  = 1'b1;
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= IDLE;
            ce_reg    <= '0;
            hit_reg   <= 1'b0;
            idx_reg   <= '0;
            mrdy_reg  <= 1'b1;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ce_reg    <= ce_next;
            hit_reg   <= hit_next;
            idx_reg   <= idx_next;
            mrdy_reg  <= mrdy_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign o_ce         = ce_reg;
    assign o_hit        = hit_reg;
    assign o_region_idx = idx_reg;
    assign o_mrdy       = mrdy_reg;
    assign o_busy       = (state_reg != IDLE);

`ifdef DECODE_FAULT_EN
    // -------------------------------------------------------------------
    // First-fault capture
    // -------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_reg;
    logic              rw_reg;
    logic              fault_reg, fault_next;
    logic [ADDR_W-1:0] fault_addr_reg, fault_addr_next;
    logic              fault_rw_reg, fault_rw_next;
    logic              miss_trig;
    logic              wait_trig;

    assign miss_trig = (state_reg == IDLE) && q_rise && i_enable && !any_match;
    assign wait_trig = (state_reg == WAIT) && e_fall;

    always_comb begin
        fault_next      = fault_reg;
        fault_addr_next = fault_addr_reg;
        fault_rw_next   = fault_rw_reg;
        // A new fault overrides a simultaneous clear.
        if ((miss_trig || wait_trig) && (!fault_reg || i_fault_clr)) begin
            fault_next      = 1'b1;
            fault_addr_next = miss_trig ? i_address : addr_reg;
            fault_rw_next   = miss_trig ? i_rw : rw_reg;
        end else if (i_fault_clr) begin
            fault_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            addr_reg       <= '0;
            rw_reg         <= 1'b0;
            fault_reg      <= 1'b0;
            fault_addr_reg <= '0;
            fault_rw_reg   <= 1'b0;
        end else begin
            // Keep the bus sample of the current cycle for a later wait fault.
            if ((state_reg == IDLE) && q_rise) begin
                addr_reg <= i_address;
                rw_reg   <= i_rw;
            end
            fault_reg      <= fault_next;
            fault_addr_reg <= fault_addr_next;
            fault_rw_reg   <= fault_rw_next;
        end
    end

    assign o_fault      = fault_reg;
    assign o_fault_addr = fault_addr_reg;
    assign o_fault_rw   = fault_rw_reg;
`else
    // R/W only matters to fault capture.
    logic unused_rw;
    assign unused_rw = i_rw;
`endif

endmodule

// File: tb/tb_bus_region_decoder.sv
// ---------------------------------------------------------------------------
// tb_bus_region_decoder
//
// Directed, self-checking bench for bus_region_decoder with the default
// parameters:
//   region 0 is disabled
//   region 1 is 0x1xxx
//   region 2 is 0x3xxx with 2 wait states
//   region 3 is 0xA000-0xA003
// E and Q are driven by hand around a 10 ns i_clk.
// Outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_bus_region_decoder;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [15:0] i_address;
    logic        i_rw;
    logic        i_E;
    logic        i_Q;
    logic        i_enable;
    logic [3:0]  i_region_gate;
    logic [3:0]  o_ce;
    logic        o_hit;
    logic [1:0]  o_region_idx;
    logic        o_mrdy;
    logic        o_busy;
`ifdef DECODE_FAULT_EN
    logic        i_fault_clr;
    logic        o_fault;
    logic [15:0] o_fault_addr;
    logic        o_fault_rw;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    bus_region_decoder dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_address     (i_address),
        .i_rw          (i_rw),
        .i_E           (i_E),
        .i_Q           (i_Q),
        .i_enable      (i_enable),
        .i_region_gate (i_region_gate),
        .o_ce          (o_ce),
        .o_hit         (o_hit),
        .o_region_idx  (o_region_idx),
        .o_mrdy        (o_mrdy),
        .o_busy        (o_busy)
`ifdef DECODE_FAULT_EN
        ,
        .i_fault_clr   (i_fault_clr),
        .o_fault       (o_fault),
        .o_fault_addr  (o_fault_addr),
        .o_fault_rw    (o_fault_rw)
`endif
    );

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Finish a bus cycle: E high long enough to be seen, Q low, then E fall.
    task automatic close_cycle();
        i_E = 1'b1;
        tick(1);
        i_Q = 1'b0;
        tick(3);
        i_E = 1'b0;
        tick(3);
    endtask

    initial begin
        i_reset       = 1'b1;
        i_address     = 16'h0000;
        i_rw          = 1'b1;
        i_E           = 1'b0;
        i_Q           = 1'b0;
        i_enable      = 1'b1;
        i_region_gate = 4'hF;
`ifdef DECODE_FAULT_EN
        i_fault_clr   = 1'b0;
`endif
        tick(2);
        i_reset = 1'b0;
        tick(1);

        // Reset state
        check("rst_ce",   32'(o_ce), 32'h0);
        check("rst_hit",  32'(o_hit), 32'h0);
        check("rst_idx",  32'(o_region_idx), 32'h0);
        check("rst_mrdy", 32'(o_mrdy), 32'h1);
        check("rst_busy", 32'(o_busy), 32'h0);
`ifdef DECODE_FAULT_EN
        check("rst_fault", 32'(o_fault), 32'h0);
`endif

        // 0x1234 -> region 1, no wait states; the third edge latches it
        i_address = 16'h1234;
        i_Q = 1'b1;
        tick(2);
        check("r1_ce_edge2", 32'(o_ce), 32'h0);
        tick(1);
        check("r1_ce",   32'(o_ce), 32'h2);
        check("r1_hit",  32'(o_hit), 32'h1);
        check("r1_idx",  32'(o_region_idx), 32'h1);
        check("r1_mrdy", 32'(o_mrdy), 32'h1);
        check("r1_busy", 32'(o_busy), 32'h1);
        i_E = 1'b1;
        tick(1);
        i_Q = 1'b0;
        tick(3);
        i_E = 1'b0;
        tick(2);
        check("r1_ce_hold", 32'(o_ce), 32'h2);
        tick(1);
        check("r1_ce_efall",  32'(o_ce), 32'h0);
        check("r1_hit_efall", 32'(o_hit), 32'h0);
        check("r1_idx_efall", 32'(o_region_idx), 32'h0);
        check("r1_busy_efall", 32'(o_busy), 32'h0);
        tick(2);

        // 0x3ABC -> region 2, MRDY low for exactly 2 cycles
        i_address = 16'h3ABC;
        i_Q = 1'b1;
        tick(3);
        check("r2_ce",    32'(o_ce), 32'h4);
        check("r2_idx",   32'(o_region_idx), 32'h2);
        check("r2_mrdy0", 32'(o_mrdy), 32'h0);
        i_E = 1'b1;
        tick(1);
        check("r2_mrdy1", 32'(o_mrdy), 32'h0);
        i_Q = 1'b0;
        tick(1);
        check("r2_mrdy_rel", 32'(o_mrdy), 32'h1);
        check("r2_busy",     32'(o_busy), 32'h1);
        check("r2_ce_hold",  32'(o_ce), 32'h4);
        tick(2);
        i_E = 1'b0;
        tick(3);
        check("r2_ce_efall",   32'(o_ce), 32'h0);
        check("r2_mrdy_efall", 32'(o_mrdy), 32'h1);
        tick(2);

        // Global enable low -> no hit, no fault
        i_enable = 1'b0;
        i_address = 16'h1234;
        i_Q = 1'b1;
        tick(3);
        check("en0_hit",  32'(o_hit), 32'h0);
        check("en0_ce",   32'(o_ce), 32'h0);
        check("en0_busy", 32'(o_busy), 32'h1);
`ifdef DECODE_FAULT_EN
        check("en0_fault", 32'(o_fault), 32'h0);
`endif
        close_cycle();
        check("en0_busy_end", 32'(o_busy), 32'h0);
        i_enable = 1'b1;

        // 0x3000 with gate[2]=0 -> blocked
        i_region_gate = 4'b1011;
        i_address = 16'h3000;
        i_rw = 1'b1;
        i_Q = 1'b1;
        tick(3);
        check("gate_ce",  32'(o_ce), 32'h0);
        check("gate_hit", 32'(o_hit), 32'h0);
`ifdef DECODE_FAULT_EN
        check("gate_fault",      32'(o_fault), 32'h1);
        check("gate_fault_addr", 32'(o_fault_addr), 32'h3000);
`endif
        close_cycle();
        i_region_gate = 4'hF;

        // 0xA001 -> region 3; a later address change must not move o_ce
        i_address = 16'hA001;
        i_Q = 1'b1;
        tick(3);
        check("a001_ce",  32'(o_ce), 32'h8);
        check("a001_idx", 32'(o_region_idx), 32'h3);
        i_address = 16'hA004;
        i_E = 1'b1;
        tick(1);
        i_Q = 1'b0;
        tick(3);
        check("a001_ce_addrchg", 32'(o_ce), 32'h8);
        i_E = 1'b0;
        tick(3);
        check("a001_ce_efall", 32'(o_ce), 32'h0);

        // 0xA004 -> outside the 4-byte window
        i_Q = 1'b1;
        tick(3);
        check("a004_hit", 32'(o_hit), 32'h0);
        check("a004_ce",  32'(o_ce), 32'h0);
`ifdef DECODE_FAULT_EN
        check("a004_first_fault_kept", 32'(o_fault_addr), 32'h3000);
`endif
        close_cycle();

        // Unmapped 0x8000 with the fault clear on the same edge
        i_address = 16'h8000;
        i_rw = 1'b1;
        i_Q = 1'b1;
        tick(2);
`ifdef DECODE_FAULT_EN
        i_fault_clr = 1'b1;
`endif
        tick(1);
`ifdef DECODE_FAULT_EN
        i_fault_clr = 1'b0;
        check("clr_new_fault",      32'(o_fault), 32'h1);
        check("clr_new_fault_addr", 32'(o_fault_addr), 32'h8000);
        check("clr_new_fault_rw",   32'(o_fault_rw), 32'h1);
`endif
        check("u8000_hit", 32'(o_hit), 32'h0);
        close_cycle();
`ifdef DECODE_FAULT_EN
        i_fault_clr = 1'b1;
        tick(1);
        i_fault_clr = 1'b0;
        check("clr_only", 32'(o_fault), 32'h0);
`endif

        // E falls while region 2 is still in its wait phase
        i_E = 1'b1;
        tick(3);
        i_address = 16'h3ABC;
        i_rw = 1'b0;
        i_Q = 1'b1;
        tick(1);
        i_E = 1'b0;
        tick(2);
        check("wv_ce",   32'(o_ce), 32'h4);
        check("wv_mrdy", 32'(o_mrdy), 32'h0);
        tick(1);
        check("wv_ce_abort",   32'(o_ce), 32'h0);
        check("wv_mrdy_abort", 32'(o_mrdy), 32'h1);
        check("wv_busy_abort", 32'(o_busy), 32'h0);
        check("wv_hit_abort",  32'(o_hit), 32'h0);
`ifdef DECODE_FAULT_EN
        check("wv_fault",      32'(o_fault), 32'h1);
        check("wv_fault_addr", 32'(o_fault_addr), 32'h3ABC);
        check("wv_fault_rw",   32'(o_fault_rw), 32'h0);
`endif
        i_Q = 1'b0;
        i_rw = 1'b1;
        tick(4);

        // Asynchronous reset in the middle of an ACTIVE cycle
        i_address = 16'h1234;
        i_Q = 1'b1;
        tick(3);
        check("ar_ce_before", 32'(o_ce), 32'h2);
        #2;
        i_reset = 1'b1;
        #1;
        check("ar_ce",   32'(o_ce), 32'h0);
        check("ar_mrdy", 32'(o_mrdy), 32'h1);
        check("ar_busy", 32'(o_busy), 32'h0);
        check("ar_hit",  32'(o_hit), 32'h0);
`ifdef DECODE_FAULT_EN
        check("ar_fault", 32'(o_fault), 32'h0);
`endif
        i_Q = 1'b0;
        tick(1);
        i_reset = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
